move_scheduler: RTL and testbench
=================================

# move_scheduler

Sequencing controller for the move/collision engine. Generates the one-cycle move strobe at a programmable rate and runs the game state machine (idle, run, pause, over). Latches local and remote direction requests between moves, rejects 180° reversals and commits both directions atomically on the strobe. Supervises remote-direction arrival and drives the receive flag and communication-error indication. Sits between the keyboard and UART front ends and `move_n_collisions`, replacing its free-running `clk_div` source.

## Interface
- `TICK_DIV`, 7_500_000: clk cycles per move (10 moves/s at 75 MHz); legal range 2..2^24-1
- `RCV_TIMEOUT`, 3: consecutive moves without a remote direction before a comms error; legal range 1..15
- `START_DIR1`, RIGHT: snake 1 direction after init
- `START_DIR2`, LEFT: snake 2 direction after init
- `clk` in 1: system clock, 75 MHz
- `rst` in 1: synchronous, active-high reset
- `start` in 1: level; begins or restarts a game
- `pause` in 1: level; holds the game while high
- `dir1_valid` in 1: one-cycle strobe; local (keyboard) direction request
- `dir1_in` in 2: `snake_pkg::direction`; local request value
- `dir2_valid` in 1: one-cycle strobe; remote (UART) direction received
- `dir2_in` in 2: `snake_pkg::direction`; remote request value
- `over` in 1: collision/game-end from the move engine
- `move_tick` out 1: one-cycle move strobe to the move engine
- `dir1`, `dir2` out 2: committed directions, stable between ticks
- `rcvdir` out 1: high with `move_tick` when a remote direction arrived in the elapsed window
- `init` out 1: one-cycle pulse; move engine reloads the map
- `com_err` out 1: sticky remote timeout error
- `state` out 2: IDLE=0, RUN=1, PAUSE=2, OVER=3

## Operation
- **FSM transitions**
  - IDLE→RUN on `start`; OVER→RUN on `start` rising edge only.
  - RUN→PAUSE while `pause`=1; PAUSE→RUN when `pause`=0.
  - RUN or PAUSE→OVER on `over`=1 or on timeout.
- **Entering RUN from IDLE/OVER**
  - Pulse `init` for one cycle.
  - Set `dir1`/`dir2`/pending registers to START values.
  - Clear the tick counter, the miss counter and `com_err`.
- **Tick counter** (24-bit)
  - Counts only in RUN; holds its value in PAUSE.
  - At count TICK_DIV-1: assert `move_tick`, then wrap to 0.
- **Pending registers** (one per snake)
  - Accepted only in RUN and PAUSE; ignored in IDLE/OVER.
  - On a valid strobe, load the request unless it is the opposite of the committed direction (UP/DOWN, LEFT/RIGHT). Opposite is decided by explicit compare, not encoding arithmetic.
  - Requests equal to the committed direction are accepted (no-op).
  - Last accepted request in a window wins.
- **Commit on `move_tick`**
  - `dir1`/`dir2` take the pending values as registered before that cycle.
  - A request arriving in the tick cycle lands in pending for the next window. It is reversal-checked against the pre-commit direction, so its check is repeated at the next commit against the new direction; a reversal is dropped at that point.
- **Remote supervision**
  - `got2` flag: set by `dir2_valid` (even if the request was rejected as a reversal); cleared on each tick.
  - `rcvdir` = `move_tick` & (`got2` | `dir2_valid` in the same cycle).
  - Miss counter: increments on each tick with `rcvdir`=0; cleared on each tick with `rcvdir`=1.
  - When it reaches RCV_TIMEOUT: set `com_err`, go to OVER.
- **OVER**
  - No ticks; `dir1`/`dir2` hold; `com_err` holds until the next init.

## Timing
- **Reset values:** `state`=IDLE, `move_tick`=0, `rcvdir`=0, `init`=0, `com_err`=0, `dir1`=START_DIR1, `dir2`=START_DIR2, counters 0.
- **All outputs registered.**
  - `init` is high in the first RUN cycle.
  - The first `move_tick` is asserted TICK_DIV cycles after `init`; the period is TICK_DIV cycles.
- **Pause** inserts exactly the paused cycle count into the period.
  - `pause` and tick in the same cycle: pause wins, no tick, counter holds at TICK_DIV-1.
- **`over` and tick in the same cycle:** `over` wins; no tick, no commit.
- **Timeout** is detected on the tick: `move_tick` still pulses that cycle, OVER and `com_err` follow one cycle later.
- **`rst` mid-game** returns to reset values on the next edge; no `init` pulse.
- **`start` held** across OVER does not restart; a deassert/reassert is required.

## Test plan
Benches use TICK_DIV=5, RCV_TIMEOUT=2.
- **Reset/start:** reset, then `start`=1 → `init` one cycle; `move_tick` every 5 cycles; `dir1`=RIGHT, `dir2`=LEFT.
- **Reversal reject:** `dir1_in`=LEFT strobe, then UP strobe in the same window → at tick `dir1`=UP. A lone LEFT strobe → `dir1` stays RIGHT.
- **Remote rcvdir/timeout:**
  - `dir2_valid` once per window → `rcvdir`=1 on each tick, `com_err`=0.
  - Stop remote strobes → two ticks with `rcvdir`=0, then `com_err`=1, `state`=OVER, ticks stop.
- **Pause:** `pause` high for 7 cycles mid-window → that tick is delayed exactly 7 cycles; `dir1_valid` during pause is committed at the next tick.
- **Collisions of events:**
  - `over` in the tick cycle → no `move_tick`, `state`=OVER.
  - `dir1_valid`=DOWN in the tick cycle → committed at the following tick.
- **Restart:** in OVER with `start` held → stays OVER. Release and reassert → `init` pulse, directions back to RIGHT/LEFT, `com_err`=0.

Source files
------------

// File: rtl/move_scheduler.sv
// -----------------------------------------------------------------------------
// move_scheduler
//
// Sequencing controller for the move/collision engine. Produces the one-cycle
// move strobe at a programmable rate, runs the game state machine
// (IDLE/RUN/PAUSE/OVER), buffers local and remote direction requests between
// moves (dropping 180-degree reversals) and commits both directions together
// on the strobe. It also watches for remote direction traffic and flags a
// sticky communication error when the remote side goes quiet.
//
// Direction encoding: UP=0, DOWN=1, LEFT=2, RIGHT=3.
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   start_i       level; begins a game from IDLE, restarts from OVER on a rising edge
//   pause_i       level; holds the game while high
//   dir1_valid_i  one-cycle strobe; local (keyboard) direction request
//   dir1_i        local request value
//   dir2_valid_i  one-cycle strobe; remote (UART) direction received
//   dir2_i        remote request value
//   over_i        game end reported by the move engine
//   move_tick_o   one-cycle move strobe
//   dir1_o        committed snake 1 direction, stable between ticks
//   dir2_o        committed snake 2 direction, stable between ticks
//   rcvdir_o      with move_tick_o: a remote direction arrived in that window
//   init_o        one-cycle pulse; move engine reloads its map
//   com_err_o     sticky remote timeout error
//   state_o       IDLE=0, RUN=1, PAUSE=2, OVER=3
// -----------------------------------------------------------------------------
module move_scheduler #(
    parameter int unsigned TICK_DIV    = 7_500_000,
    parameter int unsigned RCV_TIMEOUT = 3,
    parameter logic [1:0]  START_DIR1  = 2'd3,   // RIGHT
    parameter logic [1:0]  START_DIR2  = 2'd2    // LEFT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       dir1_valid_i,
    input  logic [1:0] dir1_i,
    input  logic       dir2_valid_i,
    input  logic [1:0] dir2_i,
    input  logic       over_i,
    output logic       move_tick_o,
    output logic [1:0] dir1_o,
    output logic [1:0] dir2_o,
    output logic       rcvdir_o,
    output logic       init_o,
    output logic       com_err_o,
    output logic [1:0] state_o
);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [23:0] CNT_LAST   = 24'(TICK_DIV - 1);
    localparam logic [3:0]  MISS_LIMIT = 4'(RCV_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    // Explicit pairwise compare keeps the reversal rule independent of the
    // numeric encoding.
    function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
        return ((a == DIR_UP)   && (b == DIR_DOWN))  ||
               ((a == DIR_DOWN) && (b == DIR_UP))    ||
               ((a == DIR_LEFT) && (b == DIR_RIGHT)) ||
               ((a == DIR_RIGHT) && (b == DIR_LEFT));
    endfunction

    state_e      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [3:0]  miss_q, miss_d;
    logic        got2_q, got2_d;
    logic [1:0]  pend1_q, pend1_d;
    logic [1:0]  pend2_q, pend2_d;
    logic [1:0]  dir1_q, dir1_d;
    logic [1:0]  dir2_q, dir2_d;
    logic        tick_q, tick_d;
    logic        rcvdir_q, rcvdir_d;
    logic        init_q, init_d;
    logic        com_err_q, com_err_d;
    logic        start_prev_q;

    logic in_game, timeout, end_game, counting, fire, launch, rcv_now;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        miss_d    = miss_q;
        got2_d    = got2_q;
        pend1_d   = pend1_q;
        pend2_d   = pend2_q;
        dir1_d    = dir1_q;
        dir2_d    = dir2_q;
        com_err_d = com_err_q;
        tick_d    = 1'b0;
        rcvdir_d  = 1'b0;
        init_d    = 1'b0;
        rcv_now   = 1'b0;

        in_game  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
        // The miss counter reaches the limit on a tick; the error is raised
        // in the cycle that tick is visible, so the tick itself still goes out.
        timeout  = in_game && (miss_q >= MISS_LIMIT);
        end_game = in_game && (over_i || timeout);
        // A cycle with pause_i high is simply not counted, which makes a
        // pause stretch the window by exactly its length. Game end beats a tick.
        counting = in_game && !pause_i && !end_game;
        fire     = counting && (cnt_q == CNT_LAST);
        launch   = ((state_q == ST_IDLE) && start_i) ||
                   ((state_q == ST_OVER) && start_i && !start_prev_q);

        if (counting) begin
            cnt_d = fire ? 24'd0 : cnt_q + 24'd1;
        end

        if (fire) begin
            rcv_now  = got2_q | dir2_valid_i;
            tick_d   = 1'b1;
            rcvdir_d = rcv_now;
            // Pending values were checked against the direction at the time
            // they arrived; re-check against the current one so a request
            // that landed during the previous commit cannot reverse the snake.
            dir1_d   = is_opposite(pend1_q, dir1_q) ? dir1_q : pend1_q;
            dir2_d   = is_opposite(pend2_q, dir2_q) ? dir2_q : pend2_q;
            pend1_d  = dir1_d;
            pend2_d  = dir2_d;
            miss_d   = rcv_now ? 4'd0 : miss_q + 4'd1;
            got2_d   = 1'b0;
        end else if (in_game && dir2_valid_i) begin
            got2_d = 1'b1;
        end

        // Requests in the commit cycle land here after the commit above and
        // therefore belong to the next window.
        if (in_game && dir1_valid_i && !is_opposite(dir1_i, dir1_q)) begin
            pend1_d = dir1_i;
        end
        if (in_game && dir2_valid_i && !is_opposite(dir2_i, dir2_q)) begin
            pend2_d = dir2_i;
        end

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (launch) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (end_game) begin
                    state_d = ST_OVER;
                end else if (pause_i) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (end_game) begin
                    state_d = ST_OVER;
                end else if (!pause_i) begin
                    state_d = ST_RUN;
                end
            end
        endcase

        if (timeout) begin
            com_err_d = 1'b1;
        end

        if (launch) begin
            init_d    = 1'b1;
            dir1_d    = START_DIR1;
            dir2_d    = START_DIR2;
            pend1_d   = START_DIR1;
            pend2_d   = START_DIR2;
            cnt_d     = 24'd0;
            miss_d    = 4'd0;
            got2_d    = 1'b0;
            com_err_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 24'd0;
            miss_q       <= 4'd0;
            got2_q       <= 1'b0;
            pend1_q      <= START_DIR1;
            pend2_q      <= START_DIR2;
            dir1_q       <= START_DIR1;
            dir2_q       <= START_DIR2;
            tick_q       <= 1'b0;
            rcvdir_q     <= 1'b0;
            init_q       <= 1'b0;
            com_err_q    <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            miss_q       <= miss_d;
            got2_q       <= got2_d;
            pend1_q      <= pend1_d;
            pend2_q      <= pend2_d;
            dir1_q       <= dir1_d;
            dir2_q       <= dir2_d;
            tick_q       <= tick_d;
            rcvdir_q     <= rcvdir_d;
            init_q       <= init_d;
            com_err_q    <= com_err_d;
            start_prev_q <= start_i;
        end
    end

    assign move_tick_o = tick_q;
    assign dir1_o      = dir1_q;
    assign dir2_o      = dir2_q;
    assign rcvdir_o    = rcvdir_q;
    assign init_o      = init_q;
    assign com_err_o   = com_err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_move_scheduler.sv
// -----------------------------------------------------------------------------
// tb_move_scheduler
//
// Directed bench for move_scheduler with TICK_DIV=5, RCV_TIMEOUT=2. The
// stimulus process pushes each expected move tick (cycle, directions, rcvdir)
// into a queue; a monitor pops and compares on every move_tick_o and reports
// ticks that are missing or unexpected. Game-state outputs are checked
// directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_move_scheduler;

    localparam logic [1:0] UP    = 2'd0;
    localparam logic [1:0] DOWN  = 2'd1;
    localparam logic [1:0] LEFT  = 2'd2;
    localparam logic [1:0] RIGHT = 2'd3;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_OVER  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i, pause_i, over_i;
    logic       dir1_valid_i, dir2_valid_i;
    logic [1:0] dir1_i, dir2_i;
    logic       move_tick_o, rcvdir_o, init_o, com_err_o;
    logic [1:0] dir1_o, dir2_o, state_o;

    typedef struct {
        int         cyc;
        logic [1:0] d1;
        logic [1:0] d2;
        logic       rcv;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    move_scheduler #(
        .TICK_DIV    (5),
        .RCV_TIMEOUT (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .pause_i      (pause_i),
        .dir1_valid_i (dir1_valid_i),
        .dir1_i       (dir1_i),
        .dir2_valid_i (dir2_valid_i),
        .dir2_i       (dir2_i),
        .over_i       (over_i),
        .move_tick_o  (move_tick_o),
        .dir1_o       (dir1_o),
        .dir2_o       (dir2_o),
        .rcvdir_o     (rcvdir_o),
        .init_o       (init_o),
        .com_err_o    (com_err_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    // Cycle n is the interval after the n-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push_exp(input int c, input logic [1:0] d1, input logic [1:0] d2, input logic r);
        exp_t e;
        e.cyc = c;
        e.d1  = d1;
        e.d2  = d2;
        e.rcv = r;
        exp_q.push_back(e);
    endtask

    // Advance to just after the rising edge that starts cycle n.
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe1(input int n, input logic [1:0] d);
        goto(n);
        dir1_valid_i = 1'b1;
        dir1_i       = d;
        goto(n + 1);
        dir1_valid_i = 1'b0;
    endtask

    task automatic strobe2(input int n, input logic [1:0] d);
        goto(n);
        dir2_valid_i = 1'b1;
        dir2_i       = d;
        goto(n + 1);
        dir2_valid_i = 1'b0;
    endtask

    // Monitor: compare every tick against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL missed_tick: no move_tick at cycle %0d, expected one", e.cyc);
        end
        if (move_tick_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tick", move_tick_o, 0);
            end else begin
                e = exp_q.pop_front();
                check("tick_cycle", cyc, e.cyc);
                check("tick_dir1", dir1_o, e.d1);
                check("tick_dir2", dir2_o, e.d2);
                check("tick_rcvdir", rcvdir_o, e.rcv);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not finish, cycle %0d, expected completion by cycle 90", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int t;
        rst          = 1'b1;
        start_i      = 1'b0;
        pause_i      = 1'b0;
        over_i       = 1'b0;
        dir1_valid_i = 1'b0;
        dir2_valid_i = 1'b0;
        dir1_i       = UP;
        dir2_i       = UP;

        // Reset values
        goto(3);
        check("rst_state", state_o, S_IDLE);
        check("rst_tick", move_tick_o, 0);
        check("rst_rcvdir", rcvdir_o, 0);
        check("rst_init", init_o, 0);
        check("rst_com_err", com_err_o, 0);
        check("rst_dir1", dir1_o, RIGHT);
        check("rst_dir2", dir2_o, LEFT);
        rst = 1'b0;
        goto(4);
        check("idle_hold", state_o, S_IDLE);

        // Game 1: start, init pulse, first tick 5 cycles after init
        goto(5);
        start_i = 1'b1;
        c0 = 6;
        t  = c0 + 5;
        push_exp(t, RIGHT, UP, 1'b1);       // lone LEFT rejected, dir2 LEFT->UP
        goto(c0);
        check("start_init", init_o, 1);
        check("start_state", state_o, S_RUN);
        check("start_dir1", dir1_o, RIGHT);
        check("start_dir2", dir2_o, LEFT);
        goto(c0 + 1);
        check("init_one_cycle", init_o, 0);
        strobe2(c0 + 1, UP);
        strobe1(c0 + 2, LEFT);

        // Window 2: LEFT rejected then UP accepted; remote DOWN rejected but seen
        push_exp(t + 5, UP, UP, 1'b1);
        strobe1(t + 1, LEFT);
        strobe1(t + 2, UP);
        strobe2(t + 3, DOWN);
        t = t + 5;

        // Window 3: 7-cycle pause stretches the window to 12 cycles
        push_exp(t + 12, LEFT, RIGHT, 1'b1);
        strobe2(t + 1, RIGHT);
        goto(t + 2);
        pause_i = 1'b1;
        strobe1(t + 4, LEFT);
        goto(t + 5);
        check("pause_state", state_o, S_PAUSE);
        goto(t + 9);
        pause_i = 1'b0;
        goto(t + 10);
        check("resume_state", state_o, S_RUN);
        t = t + 12;

        // Window 4: DOWN in the commit cycle goes to the next window
        push_exp(t + 5, LEFT, RIGHT, 1'b1);
        strobe2(t + 1, RIGHT);
        strobe1(t + 4, DOWN);
        t = t + 5;

        // Window 5: DOWN committed; UP in the commit cycle is accepted against
        // LEFT but is a reversal of DOWN, so it is dropped at the next commit.
        // Remote LEFT is a reversal of RIGHT: rejected, but still counts.
        push_exp(t + 5, DOWN, RIGHT, 1'b1);
        strobe2(t + 1, LEFT);
        strobe1(t + 4, UP);
        t = t + 5;

        // Windows 6 and 7: no remote traffic -> timeout on the second miss
        push_exp(t + 5, DOWN, RIGHT, 1'b0);
        push_exp(t + 10, DOWN, RIGHT, 1'b0);
        t = t + 10;
        goto(t);
        check("timeout_com_err_not_yet", com_err_o, 0);
        goto(t + 1);
        check("timeout_state", state_o, S_OVER);
        check("timeout_com_err", com_err_o, 1);
        goto(t + 6);
        check("over_dir1_hold", dir1_o, DOWN);
        check("over_dir2_hold", dir2_o, RIGHT);
        goto(t + 12);
        check("start_held_no_restart", state_o, S_OVER);

        // Restart needs a fresh rising edge of start
        goto(t + 13);
        start_i = 1'b0;
        goto(t + 14);
        start_i = 1'b1;
        c0 = t + 15;
        goto(c0);
        check("restart_init", init_o, 1);
        check("restart_state", state_o, S_RUN);
        check("restart_dir1", dir1_o, RIGHT);
        check("restart_dir2", dir2_o, LEFT);
        check("restart_com_err", com_err_o, 0);
        goto(c0 + 1);
        check("restart_init_one_cycle", init_o, 0);

        // Game 2: over in the tick cycle -> no tick, no commit
        strobe2(c0 + 1, UP);
        strobe1(c0 + 2, UP);
        goto(c0 + 4);
        over_i = 1'b1;
        goto(c0 + 5);
        over_i = 1'b0;
        check("over_tick_suppressed", move_tick_o, 0);
        check("over_state", state_o, S_OVER);
        check("over_no_commit", dir1_o, RIGHT);
        check("over_com_err", com_err_o, 0);

        // Game 3: synchronous reset mid-game, no init pulse
        goto(c0 + 7);
        start_i = 1'b0;
        goto(c0 + 8);
        start_i = 1'b1;
        goto(c0 + 9);
        check("game3_init", init_o, 1);
        strobe1(c0 + 10, DOWN);
        goto(c0 + 12);
        rst = 1'b1;
        goto(c0 + 13);
        check("midrst_state", state_o, S_IDLE);
        check("midrst_init", init_o, 0);
        check("midrst_dir1", dir1_o, RIGHT);
        check("midrst_tick", move_tick_o, 0);
        rst     = 1'b0;
        start_i = 1'b0;
        goto(c0 + 16);
        check("idle_after_rst", state_o, S_IDLE);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
